conv_encoder: RTL

//  Rate-1/2 feed-forward convolutional encoder: transmit end of the Viterbi link.
//  - Consumes one info bit per handshake; emits one 2-bit coded symbol.
//  - Symbols match the hard-decision branch metric unit: symbol value n pairs with BM_n.
//  - Terminates each frame with K-1 zero tail bits, so the decoder trellis ends in state 0.

---
 rtl/viterbi_pkg.sv | 34 +++
 rtl/conv_encoder.sv | 135 +++++++++++++
 2 files changed

// File: rtl/viterbi_pkg.sv
// Shared definitions for the Viterbi link: code constants, the coded symbol
// type used by both the encoder and the branch metric unit, and the parity
// helper that turns a register window into a coded symbol.
package viterbi_pkg;

  // Constraint length and generator polynomials of the reference code.
  localparam int K = 3;
  localparam logic [K-1:0] G0 = 3'b111;
  localparam logic [K-1:0] G1 = 3'b101;

  // Widest window the parity helper accepts; narrower windows and generators
  // are zero-extended, which leaves the parity unchanged.
  localparam int K_MAX = 8;

  // Coded symbol {g0,g1}; value n pairs with branch metric BM_n.
  typedef logic [1:0] symbol_t;

  // Encoder control states.
  typedef enum logic {
    ST_DATA  = 1'b0,
    ST_FLUSH = 1'b1
  } enc_state_t;

  // Parity of the window under each generator; MSB of the window is the
  // current input bit.
  function automatic symbol_t parity_sym(
    input logic [K_MAX-1:0] window,
    input logic [K_MAX-1:0] gen0,
    input logic [K_MAX-1:0] gen1
  );
    return {^(window & gen0), ^(window & gen1)};
  endfunction

endpackage

// File: rtl/conv_encoder.sv
// Rate-1/2 feed-forward convolutional encoder with ready/valid handshakes on
// both sides, a single output register stage and optional zero-tail flushing
// so every frame leaves the decoder trellis in state 0.
module conv_encoder
  import viterbi_pkg::*;
#(
  parameter int             P_K    = K,
  parameter logic [P_K-1:0] P_G0   = G0,
  parameter logic [P_K-1:0] P_G1   = G1,
  parameter bit             P_TAIL = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  input  logic       i_data,
  input  logic       i_last,
  output logic       o_ready,
  output logic       o_valid,
  output logic [1:0] o_data,
  output logic       o_last,
  input  logic       i_ready,
  output logic       o_busy
);

  // Tail counter spans 0..P_K-2.
  localparam int CNT_W = (P_K > 2) ? $clog2(P_K - 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(P_K - 2);

  enc_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [P_K-2:0]   shift_reg, shift_next;
  logic             valid_reg, valid_next;
  symbol_t          data_reg, data_next;
  logic             last_reg, last_next;

  logic             load;
  logic             in_xfer;
  logic             enc_bit;
  logic [P_K-1:0]   window;
  logic [P_K-2:0]   shifted;
  symbol_t          sym;

  // The output register may take a new symbol when empty or being drained.
  assign load    = ~valid_reg | i_ready;
  assign o_ready = (state_reg == ST_DATA) & load;
  assign in_xfer = i_valid & o_ready;

  // During the tail the encoder feeds zeros instead of the input bit.
  assign enc_bit = (state_reg == ST_DATA) ? i_data : 1'b0;

  // Window = {u, r[0], ..., r[P_K-2]}; shifted = {r[P_K-3:0], u}.
  assign window[P_K-1] = enc_bit;
  assign shifted[0]    = enc_bit;
  for (genvar gi = 0; gi < P_K - 1; gi++) begin : g_window
    assign window[P_K-2-gi] = shift_reg[gi];
  end
  for (genvar gi = 1; gi < P_K - 1; gi++) begin : g_shift
    assign shifted[gi] = shift_reg[gi-1];
  end

  assign sym = parity_sym(K_MAX'(window), K_MAX'(P_G0), K_MAX'(P_G1));

  // Next-state logic: accept info bits in DATA, emit zero-tail symbols in FLUSH.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    shift_next = shift_reg;
    valid_next = valid_reg;
    data_next  = data_reg;
    last_next  = last_reg;
    case (state_reg)
      ST_DATA: begin
        if (load) begin
          valid_next = in_xfer;
          last_next  = 1'b0;
          if (in_xfer) begin
            data_next  = sym;
            shift_next = shifted;
            if (i_last) begin
              if (P_TAIL) begin
                state_next = ST_FLUSH;
                cnt_next   = '0;
              end else begin
                // Untailed frame: end here and start the next one from state 0.
                last_next  = 1'b1;
                shift_next = '0;
              end
            end
          end
        end
      end
      ST_FLUSH: begin
        // Tail advances only on a load, so downstream stalls freeze it.
        if (load) begin
          valid_next = 1'b1;
          data_next  = sym;
          shift_next = shifted;
          cnt_next   = cnt_reg + CNT_W'(1);
          last_next  = (cnt_reg == CNT_LAST);
          if (cnt_reg == CNT_LAST) begin
            state_next = ST_DATA;
          end
        end
      end
      default: begin
        state_next = ST_DATA;
      end
    endcase
  end

  // State and output register; reset drops any frame in progress.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= ST_DATA;
      cnt_reg   <= '0;
      shift_reg <= '0;
      valid_reg <= 1'b0;
      data_reg  <= '0;
      last_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      shift_reg <= shift_next;
      valid_reg <= valid_next;
      data_reg  <= data_next;
      last_reg  <= last_next;
    end
  end

  assign o_valid = valid_reg;
  assign o_data  = data_reg;
  assign o_last  = last_reg;
  assign o_busy  = (state_reg == ST_FLUSH);

endmodule
